memory_responder: RTL and testbench

Single-port, word-organised data/instruction memory that serves the `Bundle::MemoryIn` / `Bundle::MemoryOut` request–response protocol the core issues on its imem and dmem ports. It accepts one request at a time, returns the response a fixed number of cycles later, and applies RISC-V byte, halfword and word lane selection on both stores and loads. It is instantiated once per core memory port, at the top level next to the core.

---
 rtl/memory_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_memory_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: single-port, word-organised memory that answers the core's
// MemoryIn/MemoryOut request-response protocol with a fixed latency. It applies
// RISC-V byte/halfword/word lane selection on stores and sign/zero extension on
// loads, and flags misaligned accesses.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-high
//   mem_in     - request bundle (req_valid, req.addr/data/fcn/typ)
//   mem_out    - response bundle (req_ready, res_valid, res.data)
//   misaligned - high with res_valid when the answered request was misaligned
//   busy       - high while a request is in flight (WAIT or RESP)

package Bundle;
   localparam logic       M_XRD = 1'b0;
   localparam logic       M_XWR = 1'b1;
   localparam logic [2:0] MT_X  = 3'd0;
   localparam logic [2:0] MT_B  = 3'd1;
   localparam logic [2:0] MT_H  = 3'd2;
   localparam logic [2:0] MT_W  = 3'd3;
   localparam logic [2:0] MT_BU = 3'd5;
   localparam logic [2:0] MT_HU = 3'd6;
   localparam logic [2:0] MT_WU = 3'd7;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        fcn;
      logic [2:0]  typ;
   } MemReq;

   typedef struct packed {
      logic  req_valid;
      MemReq req;
   } MemoryIn;

   typedef struct packed {
      logic [31:0] data;
   } MemResp;

   typedef struct packed {
      logic   req_ready;
      logic   res_valid;
      MemResp res;
   } MemoryOut;
endpackage

module memory_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter int LATENCY     = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  Bundle::MemoryIn  mem_in,
   output Bundle::MemoryOut mem_out,
   output logic           misaligned,
   output logic           busy
);
   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Access size codes after decode: 1 = byte, 2 = halfword, 3 = word.
   function automatic logic [1:0] f_size(input logic [2:0] typ);
      f_size = (typ[1:0] == 2'd0) ? 2'd3 : typ[1:0];  // MT_X behaves as a word
   endfunction

   function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'd2:    f_misaligned = lane[0];
         2'd3:    f_misaligned = (lane != 2'd0);
         default: f_misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'd1:    f_byte_en = 4'b0001 << lane;
         2'd2:    f_byte_en = lane[1] ? 4'b1100 : 4'b0011;
         default: f_byte_en = 4'b1111;
      endcase
   endfunction

   // Replicate the store data so every enabled lane sees the right bytes.
   function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] data);
      case (size)
         2'd1:    f_wdata = {4{data[7:0]}};
         2'd2:    f_wdata = {2{data[15:0]}};
         default: f_wdata = data;
      endcase
   endfunction

   function automatic logic [31:0] f_load(input logic [1:0] size, input logic uns,
                                          input logic [1:0] lane, input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         2'd1:    f_load = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         2'd2:    f_load = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: f_load = word;
      endcase
   endfunction

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_cnt;
   logic [3:0]      w_cnt_nxt;
   logic [AW+1:0]   r_addr;
   logic [31:0]     r_data;
   logic            r_store;
   logic [1:0]      r_size;
   logic            r_uns;
   logic [31:0]     r_mem [DEPTH_WORDS];

   logic            w_ready;
   logic            w_accept;
   logic [AW-1:0]   w_idx;
   logic [1:0]      w_lane;
   logic            w_mis;
   logic            w_we;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata;
   logic [31:0]     w_word;
   logic            w_unused_addr;

   assign w_ready       = (r_state != S_WAIT);
   assign w_accept      = mem_in.req_valid & w_ready;
   assign w_idx         = r_addr[AW+1:2];
   assign w_lane        = r_addr[1:0];
   assign w_mis         = f_misaligned(r_size, w_lane);
   assign w_we          = (r_state == S_RESP) & r_store & ~w_mis;
   assign w_be          = f_byte_en(r_size, w_lane);
   assign w_wdata       = f_wdata(r_size, r_data);
   assign w_word        = r_mem[w_idx];
   assign w_unused_addr = ^mem_in.req.addr[31:AW+2];  // high bits wrap away

   // State and countdown register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Capture the request on acceptance; inputs are ignored afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_data  <= 32'h0;
         r_store <= 1'b0;
         r_size  <= 2'd3;
         r_uns   <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= mem_in.req.addr[AW+1:0];
         r_data  <= mem_in.req.data;
         r_store <= (mem_in.req.fcn == Bundle::M_XWR);
         r_size  <= f_size(mem_in.req.typ);
         r_uns   <= mem_in.req.typ[2];
      end
   end

   // Store commit on the edge that ends RESP; reset leaves contents intact and,
   // by forcing IDLE, drops any pending store.
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Next-state logic and state-derived outputs.
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      mem_out           = '0;
      mem_out.req_ready = w_ready;
      misaligned        = 1'b0;
      busy              = 1'b0;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (r_state == S_RESP) begin
               busy              = 1'b1;
               mem_out.res_valid = 1'b1;
               misaligned        = w_mis;
               // Stores and misaligned requests answer with zero data.
               if (w_mis || r_store) begin
                  mem_out.res.data = 32'h0;
               end else begin
                  mem_out.res.data = f_load(r_size, r_uns, w_lane, w_word);
               end
            end else begin
               busy = 1'b0;
            end
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_INIT;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            busy      = 1'b1;
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = S_RESP;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (LATENCY 1 with 16 words,
// LATENCY 3, LATENCY 4). Expected responses are queued as requests are issued
// and a monitor pops and compares them whenever an instance presents res_valid.

module tb_memory_responder;
   import Bundle::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst;
   MemoryIn     mi [3];
   MemoryOut    mo [3];
   logic [2:0]  mis;
   logic [2:0]  bsy;

   memory_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut0 (
      .clk(clk), .reset(rst[0]), .mem_in(mi[0]), .mem_out(mo[0]),
      .misaligned(mis[0]), .busy(bsy[0]));
   memory_responder #(.DEPTH_WORDS(4096), .LATENCY(3)) dut1 (
      .clk(clk), .reset(rst[1]), .mem_in(mi[1]), .mem_out(mo[1]),
      .misaligned(mis[1]), .busy(bsy[1]));
   memory_responder #(.DEPTH_WORDS(4096), .LATENCY(4)) dut2 (
      .clk(clk), .reset(rst[2]), .mem_in(mi[2]), .mem_out(mo[2]),
      .misaligned(mis[2]), .busy(bsy[2]));

   typedef struct {
      int          dut;
      logic [31:0] data;
      logic        mis;
   } exp_t;

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor: every res_valid must match the oldest queued expectation.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (mo[d].res_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_resp: dut%0d got res_valid=1, required no response (t=%0t)",
                        d, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("resp_dut", 32'(d), 32'(e.dut));
               chk("resp_data", mo[d].res.data, e.data);
               chk("resp_misaligned", 32'(mis[d]), 32'(e.mis));
            end
         end
      end
   end

   task automatic set_req(input int d, input logic fcn, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] data);
      mi[d].req_valid = 1'b1;
      mi[d].req.fcn   = fcn;
      mi[d].req.typ   = typ;
      mi[d].req.addr  = addr;
      mi[d].req.data  = data;
   endtask

   task automatic push_exp(input int d, input logic [31:0] data, input logic emis);
      exp_t e;
      e.dut  = d;
      e.data = data;
      e.mis  = emis;
      exp_q.push_back(e);
   endtask

   // Present a request and return #1 after the edge that accepts it.
   task automatic issue(input int d, input logic fcn, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input logic emis);
      int n;
      n = 0;
      set_req(d, fcn, typ, addr, data);
      push_exp(d, exp, emis);
      while (!mo[d].req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: dut%0d req_ready stayed 0, required 1", d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      mi[d].req_valid = 1'b0;
      while (exp_q.size() != 0 && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 3'b111;
      for (int d = 0; d < 3; d++) begin
         mi[d] = '0;
      end
      #2;
      // Reset state on every instance.
      for (int d = 0; d < 3; d++) begin
         chk("rst_req_ready", 32'(mo[d].req_ready), 32'd1);
         chk("rst_res_valid", 32'(mo[d].res_valid), 32'd0);
         chk("rst_misaligned", 32'(mis[d]), 32'd0);
         chk("rst_busy", 32'(bsy[d]), 32'd0);
         chk("rst_res_data", mo[d].res.data, 32'h0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 3'b000;

      // LATENCY 1: back-to-back SW then LW; one response per cycle.
      issue(0, M_XWR, MT_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      chk("b2b_valid_sw", 32'(mo[0].res_valid), 32'd1);
      issue(0, M_XRD, MT_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      chk("b2b_valid_lw", 32'(mo[0].res_valid), 32'd1);
      drain(0);

      // Byte lanes.
      issue(0, M_XWR, MT_W,  32'h10, 32'h00000000, 32'h0, 1'b0);
      issue(0, M_XWR, MT_B,  32'h13, 32'h12345680, 32'h0, 1'b0);
      issue(0, M_XRD, MT_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
      issue(0, M_XRD, MT_BU, 32'h13, 32'h0, 32'h00000080, 1'b0);
      issue(0, M_XRD, MT_W,  32'h10, 32'h0, 32'h80000000, 1'b0);
      issue(0, M_XWR, MT_BU, 32'h11, 32'h0000005A, 32'h0, 1'b0);
      issue(0, M_XRD, MT_B,  32'h11, 32'h0, 32'h0000005A, 1'b0);
      issue(0, M_XRD, MT_WU, 32'h10, 32'h0, 32'h80005A00, 1'b0);

      // Halfwords, misalignment, MT_X as word.
      issue(0, M_XWR, MT_W,  32'h20, 32'h00000000, 32'h0, 1'b0);
      issue(0, M_XWR, MT_H,  32'h22, 32'hAAAA8001, 32'h0, 1'b0);
      issue(0, M_XRD, MT_H,  32'h22, 32'h0, 32'hFFFF8001, 1'b0);
      issue(0, M_XRD, MT_HU, 32'h22, 32'h0, 32'h00008001, 1'b0);
      issue(0, M_XRD, MT_H,  32'h23, 32'h0, 32'h0, 1'b1);
      issue(0, M_XWR, MT_HU, 32'h21, 32'h00001234, 32'h0, 1'b1);
      issue(0, M_XWR, MT_W,  32'h22, 32'hFFFFFFFF, 32'h0, 1'b1);
      issue(0, M_XRD, MT_W,  32'h21, 32'h0, 32'h0, 1'b1);
      issue(0, M_XWR, MT_HU, 32'h20, 32'h00007FFE, 32'h0, 1'b0);
      issue(0, M_XRD, MT_H,  32'h20, 32'h0, 32'h00007FFE, 1'b0);
      issue(0, M_XRD, MT_X,  32'h20, 32'h0, 32'h80017FFE, 1'b0);

      // Address wrap with 16 words (64 bytes).
      issue(0, M_XWR, MT_W,  32'h40, 32'h12345678, 32'h0, 1'b0);
      issue(0, M_XRD, MT_W,  32'h00, 32'h0, 32'h12345678, 1'b0);
      issue(0, M_XRD, MT_W,  32'h50, 32'h0, 32'h80005A00, 1'b0);
      drain(0);

      // LATENCY 3: accept in cycle 0, ready low cycles 1-2, response in cycle 3,
      // a request held from cycle 1 is accepted at the end of cycle 3.
      issue(1, M_XWR, MT_W, 32'h8, 32'hA5A5A5A5, 32'h0, 1'b0);
      set_req(1, M_XRD, MT_W, 32'h8, 32'h0);
      push_exp(1, 32'hA5A5A5A5, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         chk("lat3_req_ready", 32'(mo[1].req_ready), (c == 3) ? 32'd1 : 32'd0);
         chk("lat3_res_valid", 32'(mo[1].res_valid), (c == 3) ? 32'd1 : 32'd0);
         chk("lat3_busy", 32'(bsy[1]), 32'd1);
         @(posedge clk);
         #1;
      end
      mi[1].req_valid = 1'b0;
      chk("lat3_held_accepted", 32'(mo[1].req_ready), 32'd0);
      drain(1);
      chk("lat3_idle_busy", 32'(bsy[1]), 32'd0);

      // LATENCY 4: reset during WAIT drops the store and its response.
      issue(2, M_XWR, MT_W, 32'h30, 32'h11111111, 32'h0, 1'b0);
      drain(2);
      issue(2, M_XWR, MT_W, 32'h30, 32'h22222222, 32'h0, 1'b0);
      mi[2].req_valid = 1'b0;
      chk("rstmid_busy_wait", 32'(bsy[2]), 32'd1);
      @(posedge clk);
      #1;
      rst[2] = 1'b1;
      #1;
      chk("rstmid_busy", 32'(bsy[2]), 32'd0);
      chk("rstmid_res_valid", 32'(mo[2].res_valid), 32'd0);
      chk("rstmid_req_ready", 32'(mo[2].req_ready), 32'd1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst[2] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      issue(2, M_XRD, MT_W, 32'h30, 32'h0, 32'h11111111, 1'b0);
      drain(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
